dll_accum_norm: RTL and testbench
=================================

# dll_accum_norm

Integrate-and-dump and scaling stage directly upstream of the DLL truncation stage in the code tracking loop. Accumulates per-sample early and late correlator magnitudes over one dump period. At each dump it latches the 19-bit totals and finds the normalisation index: the position of the highest set bit of (early | late), floored at 9. The truncation stage consumes `index` plus either total and produces 9-bit discriminator inputs on a common scale.

## Interface
- `IN_WIDTH`, 10, width of per-sample magnitudes
- `ACC_WIDTH`, 19, accumulator and result width
- `INDEX_WIDTH`, 5, width of `index`
- `MIN_INDEX`, 9, floor of `index` (truncated output width)
- `clk`  in  1  sole clock; all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `sample_valid`  in  1  early_mag/late_mag valid this cycle
- `early_mag`  in  IN_WIDTH  unsigned early magnitude
- `late_mag`  in  IN_WIDTH  unsigned late magnitude
- `dump`  in  1  single-cycle end-of-period strobe
- `early_acc`  out  ACC_WIDTH  latched early total
- `late_acc`  out  ACC_WIDTH  latched late total
- `index`  out  INDEX_WIDTH  MSB position for truncation, range 9..18
- `overflow`  out  1  latched period saturated
- `result_valid`  out  1  one-cycle pulse; all outputs updated together
- `busy`  out  1  index search in progress; a dump is not accepted
- `dump_overrun`  out  1  sticky: a dump arrived while busy

## Operation
- Running accumulators `acc_e` and `acc_l` (ACC_WIDTH). On `sample_valid`, each adds its magnitude, zero-extended.
- Saturating add: a sum above 2^19-1 clamps to 2^19-1 and sets the period's saturation flag.
- Dump accepted when `busy`=0:
  - Accumulators, including any same-cycle sample, copy into hold registers.
  - Accumulators and the saturation flag clear; the next cycle's sample starts the new period.
- Dump while `busy`=1:
  - Dump is dropped; accumulators keep running without clearing.
  - `dump_overrun` sets and clears only on reset.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE: on accepted dump go to SEARCH, search index k=18.
  - SEARCH: test bit k of (hold_e | hold_l).
    - If bit set or k==MIN_INDEX: latch index=k, go to DONE.
    - Else k=k-1, stay in SEARCH.
  - DONE: `result_valid`=1; `early_acc`, `late_acc`, `index` and `overflow` update from the hold registers; return to IDLE.
- `busy`=1 only in SEARCH. DONE accepts a dump, same as IDLE.
- All-zero totals give index=9 and zero outputs.
- Outputs hold their values between results.

## Timing
- Reset values: `early_acc`=0, `late_acc`=0, `index`=9, `overflow`=0, `result_valid`=0, `busy`=0, `dump_overrun`=0. Accumulators and hold registers are 0; FSM in IDLE.
- Accepted dump at cycle T: SEARCH begins at T+1 with k=18. Bit k is tested at cycle T+1+(18-k).
- `result_valid` at cycle T+2+(18-k): latency 2 for index 18, latency 11 for index 9.
- Outputs are registered and change only in the `result_valid` cycle.
- Reset asserted mid-search aborts the search. No `result_valid` follows; all state returns to reset values the next cycle.
- `sample_valid` is honoured every cycle regardless of FSM state.

## Configuration
- `DLL_ACCUM_NORM_FAST_EN` defined:
  - Index comes from a single-cycle priority encoder in SEARCH.
  - `result_valid` always at T+2; `busy` high for exactly one cycle.
- Not defined: serial bit search as above, latency 2..11.
- Outputs, saturation and overrun behaviour are identical in both builds.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with random inputs -> all outputs equal their reset values; no `result_valid`.
- Small totals: 4 samples early=100, late=50, then dump at T -> `result_valid` at T+11 (serial) or T+2 (fast); early_acc=400, late_acc=200, index=9, overflow=0.
- Saturation: 1000 samples early=1023, late=0, then dump at T -> early_acc=524287, late_acc=0, overflow=1, index=18, `result_valid` at T+2.
- Dump boundary: sample 7/3 coincident with dump, sample 5/5 the next cycle, dump 10 cycles later -> first result early=7, late=3; second result early=5, late=5.
- Overrun: dump at T with totals 400/200, second dump at T+3 (serial) -> second dump dropped; `dump_overrun`=1; one `result_valid` only; accumulators not cleared by the second dump.
- Reset mid-search: dump at T, `reset_n`=0 at T+4 -> no `result_valid`; outputs at reset values from T+5.

Source files
------------

// File: rtl/dll_accum_norm.sv
`default_nettype none
// ============================================================================
// Module      : dll_accum_norm
// Description : Early/late integrate-and-dump with saturating accumulators and
//               MSB search that produces the truncation index for the DLL.
//               Build option DLL_ACCUM_NORM_FAST_EN selects a single-cycle
//               priority encoder instead of the serial bit search.
// Revision    : 1.0 - initial release
// ============================================================================
module dll_accum_norm #(
    parameter int IN_WIDTH    = 10,
    parameter int ACC_WIDTH   = 19,
    parameter int INDEX_WIDTH = 5,
    parameter int MIN_INDEX   = 9
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sample_valid,
    input  logic [IN_WIDTH-1:0]    early_mag,
    input  logic [IN_WIDTH-1:0]    late_mag,
    input  logic                   dump,
    output logic [ACC_WIDTH-1:0]   early_acc,
    output logic [ACC_WIDTH-1:0]   late_acc,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   overflow,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   dump_overrun
);

    localparam logic [INDEX_WIDTH-1:0] c_top_index = INDEX_WIDTH'(ACC_WIDTH - 1);
    localparam logic [INDEX_WIDTH-1:0] c_min_index = INDEX_WIDTH'(MIN_INDEX);
    localparam logic [ACC_WIDTH-1:0]   c_acc_max   = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_e_q, acc_e_d;
    logic [ACC_WIDTH-1:0]   acc_l_q, acc_l_d;
    logic                   sat_q, sat_d;
    logic [ACC_WIDTH-1:0]   hold_e_q, hold_e_d;
    logic [ACC_WIDTH-1:0]   hold_l_q, hold_l_d;
    logic                   hold_ovf_q, hold_ovf_d;
    logic [ACC_WIDTH-1:0]   early_acc_q, early_acc_d;
    logic [ACC_WIDTH-1:0]   late_acc_q, late_acc_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic                   overflow_q, overflow_d;
    logic                   overrun_q, overrun_d;

    logic [ACC_WIDTH:0]     w_sum_e, w_sum_l;
    logic [ACC_WIDTH-1:0]   w_next_e, w_next_l;
    logic                   w_sat_next;
    logic                   w_dump_accept;
    logic [ACC_WIDTH-1:0]   w_hold_or;
    logic                   w_found;
    logic [INDEX_WIDTH-1:0] w_found_index;

    // Saturating accumulation; the result includes any sample arriving with a dump.
    always_comb begin
        w_sum_e    = {1'b0, acc_e_q} + (ACC_WIDTH + 1)'(early_mag);
        w_sum_l    = {1'b0, acc_l_q} + (ACC_WIDTH + 1)'(late_mag);
        w_next_e   = acc_e_q;
        w_next_l   = acc_l_q;
        w_sat_next = sat_q;
        if (sample_valid) begin
            w_next_e   = w_sum_e[ACC_WIDTH] ? c_acc_max : w_sum_e[ACC_WIDTH-1:0];
            w_next_l   = w_sum_l[ACC_WIDTH] ? c_acc_max : w_sum_l[ACC_WIDTH-1:0];
            w_sat_next = sat_q | w_sum_e[ACC_WIDTH] | w_sum_l[ACC_WIDTH];
        end
    end

    assign w_dump_accept = dump && (state_q != ST_SEARCH);
    assign w_hold_or     = hold_e_q | hold_l_q;

    always_comb begin
        acc_e_d    = w_next_e;
        acc_l_d    = w_next_l;
        sat_d      = w_sat_next;
        hold_e_d   = hold_e_q;
        hold_l_d   = hold_l_q;
        hold_ovf_d = hold_ovf_q;
        overrun_d  = overrun_q;
        if (w_dump_accept) begin
            hold_e_d   = w_next_e;
            hold_l_d   = w_next_l;
            hold_ovf_d = w_sat_next;
            acc_e_d    = '0;
            acc_l_d    = '0;
            sat_d      = 1'b0;
        end else if (dump) begin
            overrun_d  = 1'b1;
        end
    end

`ifdef DLL_ACCUM_NORM_FAST_EN
    always_comb begin
        w_found       = 1'b1;
        w_found_index = c_min_index;
        for (int i = MIN_INDEX; i < ACC_WIDTH; i++) begin
            if (w_hold_or[i]) begin
                w_found_index = INDEX_WIDTH'(i);
            end
        end
    end
`else
    logic [INDEX_WIDTH-1:0] k_q, k_d;

    // One bit per cycle, from the top down; the floor terminates the search.
    always_comb begin
        w_found       = w_hold_or[k_q] || (k_q == c_min_index);
        w_found_index = k_q;
        k_d           = k_q;
        if (w_dump_accept) begin
            k_d = c_top_index;
        end else if (state_q == ST_SEARCH) begin
            k_d = k_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k_q <= c_top_index;
        end else begin
            k_q <= k_d;
        end
    end
`endif

    // Output registers load on the SEARCH->DONE edge so they are already
    // valid during the result_valid cycle.
    always_comb begin
        state_d     = state_q;
        early_acc_d = early_acc_q;
        late_acc_d  = late_acc_q;
        index_d     = index_q;
        overflow_d  = overflow_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = w_dump_accept ? ST_SEARCH : ST_IDLE;
            end
            ST_SEARCH: begin
                if (w_found) begin
                    state_d     = ST_DONE;
                    index_d     = w_found_index;
                    early_acc_d = hold_e_q;
                    late_acc_d  = hold_l_q;
                    overflow_d  = hold_ovf_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            acc_e_q     <= '0;
            acc_l_q     <= '0;
            sat_q       <= 1'b0;
            hold_e_q    <= '0;
            hold_l_q    <= '0;
            hold_ovf_q  <= 1'b0;
            early_acc_q <= '0;
            late_acc_q  <= '0;
            index_q     <= c_min_index;
            overflow_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_e_q     <= acc_e_d;
            acc_l_q     <= acc_l_d;
            sat_q       <= sat_d;
            hold_e_q    <= hold_e_d;
            hold_l_q    <= hold_l_d;
            hold_ovf_q  <= hold_ovf_d;
            early_acc_q <= early_acc_d;
            late_acc_q  <= late_acc_d;
            index_q     <= index_d;
            overflow_q  <= overflow_d;
            overrun_q   <= overrun_d;
        end
    end

    assign early_acc    = early_acc_q;
    assign late_acc     = late_acc_q;
    assign index        = index_q;
    assign overflow     = overflow_q;
    assign result_valid = (state_q == ST_DONE);
    assign busy         = (state_q == ST_SEARCH);
    assign dump_overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dll_accum_norm.sv
`default_nettype none
// ============================================================================
// Module      : tb_dll_accum_norm
// Description : Directed plus random stimulus against a period-level model of
//               the integrate-and-dump / index search block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dll_accum_norm;

    localparam int IN_W    = 10;
    localparam int ACC_W   = 19;
    localparam int IDX_W   = 5;
    localparam int MIN_IDX = 9;
    localparam int MAXV    = (1 << ACC_W) - 1;
`ifdef DLL_ACCUM_NORM_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             sample_valid;
    logic [IN_W-1:0]  early_mag;
    logic [IN_W-1:0]  late_mag;
    logic             dump;
    logic [ACC_W-1:0] early_acc;
    logic [ACC_W-1:0] late_acc;
    logic [IDX_W-1:0] index;
    logic             overflow;
    logic             result_valid;
    logic             busy;
    logic             dump_overrun;

    dll_accum_norm #(
        .IN_WIDTH    (IN_W),
        .ACC_WIDTH   (ACC_W),
        .INDEX_WIDTH (IDX_W),
        .MIN_INDEX   (MIN_IDX)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .early_mag    (early_mag),
        .late_mag     (late_mag),
        .dump         (dump),
        .early_acc    (early_acc),
        .late_acc     (late_acc),
        .index        (index),
        .overflow     (overflow),
        .result_valid (result_valid),
        .busy         (busy),
        .dump_overrun (dump_overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int rv_count = 0;

    // Period-level reference state
    int me, ml, he, hl, hk, e0, rdue;
    bit msat, hsat, pending;
    int xe, xl, xidx;
    bit xovf, xrv, xbusy, xovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int msb_floor(input int v);
        for (int i = ACC_W - 1; i >= MIN_IDX; i--) begin
            if (v[i]) return i;
        end
        return MIN_IDX;
    endfunction

    task automatic model_edge(input bit sv, input int em, input int lm, input bit d);
        int se, sl;
        bit sat, dropped, fin;
        if (!reset_n) begin
            me = 0; ml = 0; msat = 0; he = 0; hl = 0; hk = MIN_IDX; hsat = 0;
            pending = 0; e0 = 0; rdue = 0;
            xe = 0; xl = 0; xidx = MIN_IDX; xovf = 0; xrv = 0; xbusy = 0; xovr = 0;
        end else begin
            se = me; sl = ml; sat = msat;
            if (sv) begin
                se = me + em;
                sl = ml + lm;
                if (se > MAXV) begin se = MAXV; sat = 1; end
                if (sl > MAXV) begin sl = MAXV; sat = 1; end
            end
            dropped = pending && (edge_n > e0) && (edge_n <= rdue);
            fin     = pending && (edge_n == rdue);
            xrv     = fin;
            if (fin) begin
                xe = he; xl = hl; xidx = hk; xovf = hsat; pending = 0;
            end
            if (d && dropped) xovr = 1;
            if (d && !dropped) begin
                he = se; hl = sl; hsat = sat;
                hk = msb_floor(se | sl);
                e0 = edge_n;
                rdue = edge_n + 1 + (FAST ? 0 : (ACC_W - 1 - hk));
                pending = 1;
                me = 0; ml = 0; msat = 0;
            end else begin
                me = se; ml = sl; msat = sat;
            end
            xbusy = pending && (edge_n >= e0) && (edge_n < rdue);
        end
    endtask

    task automatic step(input bit sv, input int em, input int lm, input bit d);
        sample_valid = sv;
        early_mag    = IN_W'(em);
        late_mag     = IN_W'(lm);
        dump         = d;
        @(posedge clk);
        edge_n++;
        model_edge(sv, em, lm, d);
        #1;
        if (result_valid === 1'b1) rv_count++;
        chk("result_valid", result_valid, xrv);
        chk("busy", busy, xbusy);
        chk("dump_overrun", dump_overrun, xovr);
        chk("early_acc", early_acc, xe);
        chk("late_acc", late_acc, xl);
        chk("index", index, xidx);
        chk("overflow", overflow, xovf);
    endtask

    task automatic wait_rv(input int t0, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (n < 20 && lat < 0) begin
            step(0, 0, 0, 0);
            n++;
            if (result_valid === 1'b1) lat = edge_n - t0 + 1;
        end
        chk("rv_timeout", (lat >= 0), 1);
    endtask

    initial begin
        int t0, lat, rv0, off;
        reset_n = 1'b0;
        sample_valid = 1'b0; early_mag = '0; late_mag = '0; dump = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 1));
        end
        chk("reset_index", index, MIN_IDX);
        reset_n = 1'b1;

        // Small totals
        for (int i = 0; i < 4; i++) step(1, 100, 50, 0);
        step(0, 0, 0, 1);
        t0 = edge_n;
        wait_rv(t0, lat);
        chk("small_latency", lat, FAST ? 2 : 11);
        chk("small_early", early_acc, 400);
        chk("small_late", late_acc, 200);
        chk("small_index", index, 9);
        chk("small_ovf", overflow, 0);

        // Saturation
        for (int i = 0; i < 1000; i++) step(1, 1023, 0, 0);
        step(0, 0, 0, 1);
        t0 = edge_n;
        wait_rv(t0, lat);
        chk("sat_latency", lat, 2);
        chk("sat_early", early_acc, 524287);
        chk("sat_late", late_acc, 0);
        chk("sat_ovf", overflow, 1);
        chk("sat_index", index, 18);

        // Sample coincident with dump belongs to the closing period
        step(1, 7, 3, 1);
        t0 = edge_n;
        step(1, 5, 5, 0);
        wait_rv(t0, lat);
        chk("bnd1_early", early_acc, 7);
        chk("bnd1_late", late_acc, 3);
        step(0, 0, 0, 1);
        t0 = edge_n;
        wait_rv(t0, lat);
        chk("bnd2_early", early_acc, 5);
        chk("bnd2_late", late_acc, 5);

        // Overrun: second dump during search is dropped, accumulators keep running
        off = FAST ? 1 : 3;
        for (int i = 0; i < 4; i++) step(1, 100, 50, 0);
        step(0, 0, 0, 1);
        t0 = edge_n;
        rv0 = rv_count;
        for (int i = 1; i < off; i++) step(1, 2, 2, 0);
        step(1, 2, 2, 1);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
        chk("ovr_flag", dump_overrun, 1);
        chk("ovr_one_result", rv_count - rv0, 1);
        chk("ovr_first_early", early_acc, 400);
        step(0, 0, 0, 1);
        t0 = edge_n;
        wait_rv(t0, lat);
        chk("ovr_carry_early", early_acc, 2 * off);
        chk("ovr_carry_late", late_acc, 2 * off);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0);

        // Reset during search
        step(1, 3, 3, 0);
        step(1, 3, 3, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        reset_n = 1'b0;
        step(0, 0, 0, 0);
        reset_n = 1'b1;
        rv0 = rv_count;
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
        chk("rst_no_result", rv_count - rv0, 0);
        chk("rst_early", early_acc, 0);
        chk("rst_index", index, MIN_IDX);
        chk("rst_overrun", dump_overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
